// File: rtl/seq_frame_tx.sv
// -----------------------------------------------------------------------------
// seq_frame_tx
//   Serial frame transmitter. A load accepted while idle sends a fixed sync
//   pattern, then the parallel payload MSB first, then an optional even-parity
//   bit. After every frame or abort the line is held low for GAP_CYC cycles.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | ready=1, line low, waiting for load
//   SYNC  | shifting out SYNC_PAT, MSB first
//   DATA  | shifting out latched payload, MSB first
//   PAR   | single even-parity bit
//   GAP   | line held low for GAP_CYC cycles
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   data_in    in   payload, sampled when load && ready
//   load       in   request to send data_in
//   abort      in   synchronous frame abort (SYNC/DATA/PAR only)
//   ready      out  idle, a load will be accepted
//   dout       out  registered serial data
//   dout_en    out  high while dout carries a frame bit
//   frame_done out  one-cycle pulse coincident with the last frame bit
// -----------------------------------------------------------------------------
module seq_frame_tx #(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 4'b1010,
  parameter bit                PARITY_EN = 1'b1,
  parameter int                GAP_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic              abort,
  output logic              ready,
  output logic              dout,
  output logic              dout_en,
  output logic              frame_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  // With no gap configured, a finished or aborted frame returns straight to idle.
  localparam logic [2:0] S_END = (GAP_CYC > 0) ? S_GAP : S_IDLE;

  localparam int MAX_A = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
  localparam int MAX_C = (GAP_CYC > MAX_A) ? GAP_CYC : MAX_A;
  localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [SYNC_W-1:0] sync_q, sync_d, sync_src;
  logic              par_q, par_d;
  logic              dout_d, dout_en_d, frame_done_d;

  // Outputs are registered, so they are decoded from the *next* state: the
  // first sync bit appears in the cycle right after the accepting edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    sync_d   = sync_q;
    par_d    = par_q;
    sync_src = sync_q;

    case (state_q)
      S_IDLE: begin
        // load has priority over abort here; abort is meaningless while idle
        if (load) begin
          state_d  = S_SYNC;
          cnt_d    = '0;
          shift_d  = data_in;
          par_d    = ^data_in;
          sync_src = SYNC_PAT;
        end
      end
      S_SYNC: begin
        if (abort) begin
          state_d = S_END;
          cnt_d   = '0;
        end else if (cnt_q == SYNC_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (abort) begin
          state_d = S_END;
          cnt_d   = '0;
        end else if (cnt_q == DATA_LAST) begin
          state_d = PARITY_EN ? S_PAR : S_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAR: begin
        state_d = S_END;
        cnt_d   = '0;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    dout_d       = 1'b0;
    dout_en_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_d)
      S_SYNC: begin
        dout_d    = sync_src[SYNC_W-1];
        sync_d    = sync_src << 1;
        dout_en_d = 1'b1;
      end
      S_DATA: begin
        dout_d       = shift_q[DATA_W-1];
        shift_d      = shift_q << 1;
        dout_en_d    = 1'b1;
        frame_done_d = !PARITY_EN && (cnt_d == DATA_LAST);
      end
      S_PAR: begin
        dout_d       = par_q;
        dout_en_d    = 1'b1;
        frame_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      sync_q     <= '0;
      par_q      <= 1'b0;
      ready      <= 1'b1;
      dout       <= 1'b0;
      dout_en    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sync_q     <= sync_d;
      par_q      <= par_d;
      ready      <= (state_d == S_IDLE);
      dout       <= dout_d;
      dout_en    <= dout_en_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
